pwm_oc_bank: RTL and testbench

Multi-channel, double-buffered output-compare PWM generator driven by the shared free-running timebase `tb`. Each channel generates the I/Q pulse pair used by the 399 PWM DAC path, with half-step resolution on the falling edge. New compare values are staged in shadow registers and committed atomically to all channels at timebase wrap (`tb == 0`). This block replaces single-channel compare units with direct combinational compare inputs.

---
 rtl/pwm_oc_pkg.sv | 21 ++
 rtl/pwm_oc_chan.sv | 79 +++++++
 rtl/pwm_oc_bank.sv | 75 +++++++
 tb/tb_pwm_oc_bank.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_oc_pkg.sv
// Shared constants, types and helpers for the output-compare PWM bank.
// Pulls the default timebase width and channel count into one place.
package pwm_oc_pkg;

  localparam int PWM_TB_WIDTH_DEF = 17;
  localparam int PWM_NCH_DEF      = 4;

  localparam int PWM_CMP_W = PWM_TB_WIDTH_DEF;

  // cmpL carries one extra LSB: the falling-edge half-step bit.
  typedef struct packed {
    logic [PWM_CMP_W-1:0] cmpH;
    logic [PWM_CMP_W:0]   cmpL;
  } pwm_cmp_t;

  // Channel-select width; a single channel still needs one select bit.
  function automatic int pwm_chw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pwm_oc_chan.sv
// One output-compare channel: shadow/active compare pair, armed flag and
// the registered I/Q pulse pair with half-step falling edge.
module pwm_oc_chan
  import pwm_oc_pkg::*;
#(
  parameter int WIDTH = PWM_TB_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] tb,
  input  logic             en,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_cmph,
  input  logic [WIDTH:0]   wr_cmpl,
  input  logic             xfer,
  output logic             pwm_i,
  output logic             pwm_q
);

  typedef struct packed {
    logic [WIDTH-1:0] cmph;
    logic [WIDTH:0]   cmpl;
  } cmp_t;

  cmp_t shadow_reg;
  cmp_t active_reg;
  logic armed_reg;
  logic i_reg;
  logic q_reg;
  logic i_next;
  logic q_next;
  logic hit_h;
  logic hit_l;

  assign hit_h = (tb == active_reg.cmph);
  assign hit_l = (tb == active_reg.cmpl[WIDTH:1]);

  always_comb begin
    i_next = i_reg & q_reg;
    q_next = i_reg & q_reg;
    if (hit_h) begin
      i_next = 1'b1;
      q_next = 1'b1;
    end else if (hit_l) begin
      // The half-step bit keeps I up for one more cycle after Q drops.
      i_next = active_reg.cmpl[0];
      q_next = 1'b0;
    end
    if (!en || !armed_reg) begin
      i_next = 1'b0;
      q_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_reg <= '0;
      active_reg <= '0;
      armed_reg  <= 1'b0;
      i_reg      <= 1'b0;
      q_reg      <= 1'b0;
    end else begin
      if (wr) begin
        shadow_reg.cmph <= wr_cmph;
        shadow_reg.cmpl <= wr_cmpl;
      end
      if (xfer) begin
        active_reg <= shadow_reg;
        armed_reg  <= 1'b1;
      end
      i_reg <= i_next;
      q_reg <= q_next;
    end
  end

  assign pwm_i = i_reg;
  assign pwm_q = q_reg;

endmodule

// File: rtl/pwm_oc_bank.sv
// Multi-channel double-buffered output-compare PWM bank. Owns the commit
// handshake and broadcasts a transfer strobe to every channel at wrap.
module pwm_oc_bank
  import pwm_oc_pkg::*;
#(
  parameter  int WIDTH = PWM_TB_WIDTH_DEF,
  parameter  int NCH   = PWM_NCH_DEF,
  localparam int CHW   = pwm_chw(NCH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] tb,
  input  logic             en,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [CHW-1:0]   wr_ch,
  input  logic [WIDTH-1:0] wr_cmpH,
  input  logic [WIDTH:0]   wr_cmpL,
  input  logic             commit,
  output logic             pending,
  output logic             upd,
  output logic [NCH-1:0]   pwmI,
  output logic [NCH-1:0]   pwmQ
);

  logic pending_reg;
  logic upd_reg;
  logic tb_wrap;
  logic xfer;
  logic wr_accept;

  assign tb_wrap   = (tb == '0);
  assign xfer      = pending_reg && tb_wrap;
  assign wr_ready  = !pending_reg;
  assign wr_accept = wr_valid && wr_ready;
  assign pending   = pending_reg;
  assign upd       = upd_reg;

  // Once pending, only the wrap clears it; extra commits are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_reg <= 1'b0;
      upd_reg     <= 1'b0;
    end else begin
      if (pending_reg) begin
        pending_reg <= !tb_wrap;
      end else begin
        pending_reg <= commit;
      end
      upd_reg <= xfer;
    end
  end

  // Select codes at or above NCH match no channel, so those writes vanish.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    logic wr_hit;
    assign wr_hit = wr_accept && (wr_ch == CHW'(gi));

    pwm_oc_chan #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .tb     (tb),
      .en     (en),
      .wr     (wr_hit),
      .wr_cmph(wr_cmpH),
      .wr_cmpl(wr_cmpL),
      .xfer   (xfer),
      .pwm_i  (pwmI[gi]),
      .pwm_q  (pwmQ[gi])
    );
  end

endmodule

// File: tb/tb_pwm_oc_bank.sv
// Self-checking bench for pwm_oc_bank: directed window table, hand-written
// handshake/reset/enable sequences, and a randomized run against a model.
`timescale 1ns/1ps
module tb_pwm_oc_bank;
  import pwm_oc_pkg::*;

  localparam int WIDTH = PWM_TB_WIDTH_DEF;
  localparam int NCH   = PWM_NCH_DEF;
  localparam int CHW   = pwm_chw(NCH);
  localparam int P     = 100;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] tb = '0;
  logic             en = 1'b0;
  logic             wr_valid = 1'b0;
  logic [CHW-1:0]   wr_ch = '0;
  logic [WIDTH-1:0] wr_cmpH = '0;
  logic [WIDTH:0]   wr_cmpL = '0;
  logic             commit = 1'b0;
  logic             wr_ready;
  logic             pending;
  logic             upd;
  logic [NCH-1:0]   pwmI;
  logic [NCH-1:0]   pwmQ;

  always #5 clk = ~clk;

  pwm_oc_bank #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk(clk), .rst(rst), .tb(tb), .en(en),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_ch(wr_ch),
    .wr_cmpH(wr_cmpH), .wr_cmpL(wr_cmpL), .commit(commit),
    .pending(pending), .upd(upd), .pwmI(pwmI), .pwmQ(pwmQ)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state, advanced once per clock from the behavioural rules.
  logic [WIDTH-1:0] m_sh_h  [NCH];
  logic [WIDTH:0]   m_sh_l  [NCH];
  logic [WIDTH-1:0] m_act_h [NCH];
  logic [WIDTH:0]   m_act_l [NCH];
  logic [NCH-1:0]   m_armed, m_i, m_q;
  logic             m_pend, m_upd;

  logic [NCH-1:0] obs_i [0:P];
  logic [NCH-1:0] obs_q [0:P];

  typedef struct {
    int       ch;
    pwm_cmp_t cmp;
    int       rise;
    int       qfall;
    int       ifall;
  } rec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) begin
      m_sh_h[c] = '0; m_sh_l[c] = '0; m_act_h[c] = '0; m_act_l[c] = '0;
    end
    m_armed = '0; m_i = '0; m_q = '0; m_pend = 1'b0; m_upd = 1'b0;
  endtask

  task automatic model_step();
    logic [NCH-1:0] ni, nq;
    logic do_xfer;
    do_xfer = m_pend && (tb == 0);
    for (int c = 0; c < NCH; c++) begin
      if (!en || !m_armed[c]) begin
        ni[c] = 1'b0; nq[c] = 1'b0;
      end else if (tb == m_act_h[c]) begin
        ni[c] = 1'b1; nq[c] = 1'b1;
      end else if (tb == m_act_l[c][WIDTH:1]) begin
        ni[c] = m_act_l[c][0]; nq[c] = 1'b0;
      end else begin
        ni[c] = m_i[c] & m_q[c]; nq[c] = m_i[c] & m_q[c];
      end
    end
    if (wr_valid && !m_pend && int'(wr_ch) < NCH) begin
      m_sh_h[wr_ch] = wr_cmpH;
      m_sh_l[wr_ch] = wr_cmpL;
    end
    if (do_xfer) begin
      for (int c = 0; c < NCH; c++) begin
        m_act_h[c] = m_sh_h[c];
        m_act_l[c] = m_sh_l[c];
      end
      m_armed = '1;
    end
    m_pend = m_pend ? (tb != 0) : commit;
    m_upd  = do_xfer;
    m_i = ni;
    m_q = nq;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_step();
    #1;
    check($sformatf("cycle_tb%0d", tb), {pwmI, pwmQ, pending, upd, wr_ready},
          {m_i, m_q, m_pend, m_upd, !m_pend});
  endtask

  task automatic drive(input logic v, input int ch, input int h, input int l, input logic c);
    wr_valid = v;
    wr_ch    = CHW'(ch);
    wr_cmpH  = WIDTH'(h);
    wr_cmpL  = (WIDTH+1)'(l);
    commit   = c;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_clear();
    step();
    step();
    rst = 1'b1;
  endtask

  // Steps tb through 0..P-1; obs[d] holds the outputs seen while tb == d (d == P is the wrap).
  task automatic run_period();
    for (int t = 0; t < P; t++) begin
      tb = WIDTH'(t);
      step();
      obs_i[t+1] = pwmI;
      obs_q[t+1] = pwmQ;
    end
  endtask

  task automatic check_window(input string name, input int ch, input int rise,
                              input int qfall, input int ifall);
    int bad_i, bad_q;
    bad_i = 0; bad_q = 0;
    for (int d = 1; d <= P; d++) begin
      if (obs_i[d][ch] !== ((d >= rise) && (d < ifall))) bad_i++;
      if (obs_q[d][ch] !== ((d >= rise) && (d < qfall))) bad_q++;
    end
    check({name, "_I_bad_cycles"}, bad_i, 0);
    check({name, "_Q_bad_cycles"}, bad_q, 0);
  endtask

  function automatic rec_t mk(input int ch, input int h, input int l,
                              input int rise, input int qf, input int ifl);
    rec_t r;
    r.ch = ch;
    r.cmp.cmpH = PWM_CMP_W'(h);
    r.cmp.cmpL = (PWM_CMP_W+1)'(l);
    r.rise = rise; r.qfall = qf; r.ifall = ifl;
    return r;
  endfunction

  initial begin
    rec_t recs[6];
    int   cnt_a, cnt_b;

    // Windows in displayed tb; a fall of P+1 means the pulse outlives the period.
    recs[0] = mk(0, 10, 21, 11, P+1, P+1);  // equal counts: rise wins, never falls
    recs[1] = mk(1,  5, 40,  6,  21,  21);
    recs[2] = mk(1,  5, 41,  6,  21,  22);
    recs[3] = mk(3,  7, 14,  8, P+1, P+1);
    recs[4] = mk(2, 10, 61, 11,  31,  32);
    recs[5] = mk(3, 90, 20, 91, P+1, P+1);  // fall lands in the next period

    en = 1'b1;
    model_clear();
    #1;
    check("reset_outputs", {pwmI, pwmQ, pending, upd}, 0);
    check("reset_wr_ready", wr_ready, 1);
    do_reset();

    foreach (recs[k]) begin
      do_reset();
      cnt_a = 0;
      for (int t = 40; t < P; t++) begin
        tb = WIDTH'(t);
        if (t == 41) drive(1, recs[k].ch, recs[k].cmp.cmpH, recs[k].cmp.cmpL, 1);
        else         drive(0, 0, 0, 0, 0);
        step();
        if ((pwmI | pwmQ) != 0) cnt_a++;
      end
      check($sformatf("rec%0d_quiet_before_wrap", k), cnt_a, 0);
      run_period();
      check_window($sformatf("rec%0d", k), recs[k].ch, recs[k].rise, recs[k].qfall, recs[k].ifall);
      $display("rec %0d ch%0d cmpH=%0d cmpL=%0d applied", k, recs[k].ch,
               recs[k].cmp.cmpH, recs[k].cmp.cmpL);
    end

    // Commit in the tb == 0 cycle waits a full period; writes meanwhile are refused.
    do_reset();
    tb = '0;
    drive(1, 0, 5, 40, 1);
    step();
    cnt_a = int'(pending); cnt_b = int'(wr_ready);
    for (int t = 1; t < P; t++) begin
      tb = WIDTH'(t);
      drive(1, 0, 50, 80, t == 50);
      step();
      cnt_a += int'(pending); cnt_b += int'(wr_ready);
    end
    check("wait_pending_cycles", cnt_a, P);
    check("wait_ready_cycles", cnt_b, 0);
    drive(0, 0, 0, 0, 0);
    tb = '0;
    step();
    check("wrap_upd_pulse", {pending, upd}, 2'b01);
    run_period();
    check("upd_one_cycle", obs_i[1][0] | upd, 0);
    check_window("late_commit", 0, 6, 21, 21);
    $display("seq late_commit finished");

    // Asynchronous reset while ch0 is high, then no pulses without a new commit.
    for (int t = 0; t < 10; t++) begin
      tb = WIDTH'(t);
      step();
    end
    check("pre_reset_high", pwmI[0] & pwmQ[0], 1);
    rst = 1'b0;
    model_clear();
    #1;
    check("async_reset_drop", {pwmI, pwmQ}, 0);
    step();
    step();
    rst = 1'b1;
    cnt_a = 0;
    for (int r = 0; r < 2; r++) begin
      run_period();
      for (int d = 1; d <= P; d++) if ((obs_i[d] | obs_q[d]) != 0) cnt_a++;
    end
    check("post_reset_silent", cnt_a, 0);
    $display("seq reset_mid_period finished");

    // Three cycles of en == 0 in mid-pulse kill it until the next rise compare.
    do_reset();
    tb = WIDTH'(41);
    drive(1, 1, 5, 40, 1);
    step();
    drive(0, 0, 0, 0, 0);
    for (int t = 42; t < P; t++) begin
      tb = WIDTH'(t);
      step();
    end
    run_period();
    for (int t = 0; t < P; t++) begin
      tb = WIDTH'(t);
      en = !(t >= 10 && t <= 12);
      step();
      obs_i[t+1] = pwmI;
      obs_q[t+1] = pwmQ;
    end
    en = 1'b1;
    check_window("en_gap", 1, 6, 11, 11);
    run_period();
    check_window("en_restart", 1, 6, 21, 21);
    $display("seq enable_gap finished");

    // Randomized traffic on a short period, compared cycle by cycle.
    do_reset();
    for (int r = 0; r < 40; r++) begin
      for (int t = 0; t < 40; t++) begin
        tb = WIDTH'(t);
        en = ($urandom_range(0, 19) != 0);
        drive($urandom_range(0, 1), $urandom_range(0, NCH-1), $urandom_range(0, 47),
              $urandom_range(0, 95), $urandom_range(0, 9) == 0);
        step();
      end
    end
    drive(0, 0, 0, 0, 0);
    $display("seq random finished");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
